// File: rtl/mem_port_arbiter.sv
// Shared program/data memory port arbiter: one access at a time, fixed read latency,
// data-over-fetch priority with a bounded number of consecutive data wins while fetch waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic              r_owner_dm;
  logic              r_owner_we;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [SC_W-1:0]   r_starve_cnt;

  logic              w_arb;
  logic              w_starved;
  logic              w_grant_if;
  logic              w_grant_dm;
  logic [SC_W-1:0]   w_starve_nxt;

  // Arbitration is only meaningful in IDLE and RESP; elsewhere requests are ignored.
  always_comb begin
    w_arb        = (r_state == S_IDLE) || (r_state == S_RESP);
    w_starved    = (r_starve_cnt == SC_W'(STARVE_MAX));
    w_grant_if   = w_arb && if_req && (!dm_req || w_starved);
    w_grant_dm   = w_arb && dm_req && !w_grant_if;
    w_starve_nxt = r_starve_cnt;
    if (w_arb) begin
      if (w_grant_if || !if_req)
        w_starve_nxt = '0;
      else if (w_grant_dm && !w_starved)
        w_starve_nxt = r_starve_cnt + SC_W'(1);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner_dm   <= 1'b0;
      r_owner_we   <= 1'b0;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      if_gnt       <= 1'b0;
      if_rvalid    <= 1'b0;
      if_rdata     <= '0;
      dm_gnt       <= 1'b0;
      dm_rvalid    <= 1'b0;
      dm_rdata     <= '0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      // Strobes default low so each one is a single-cycle pulse.
      if_gnt       <= 1'b0;
      dm_gnt       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      if_rvalid    <= 1'b0;
      dm_rvalid    <= 1'b0;
      r_starve_cnt <= w_starve_nxt;

      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_grant_dm) begin
            r_state    <= S_ISSUE;
            busy       <= 1'b1;
            r_owner_dm <= 1'b1;
            r_owner_we <= dm_we;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            dm_gnt     <= 1'b1;
            mem_rd     <= !dm_we;
            mem_wr     <= dm_we;
          end else if (w_grant_if) begin
            r_state    <= S_ISSUE;
            busy       <= 1'b1;
            r_owner_dm <= 1'b0;
            r_owner_we <= 1'b0;
            mem_addr   <= if_addr;
            if_gnt     <= 1'b1;
            mem_rd     <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= CNT_W'(MEM_LAT - 1);
        end

        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= S_RESP;
            if (r_owner_dm) begin
              dm_rvalid <= 1'b1;
              if (!r_owner_we)
                dm_rdata <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 build.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;

  logic        if_req, if_gnt, if_rvalid;
  logic [12:0] if_addr;
  logic [15:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [12:0] dm_addr;
  logic [15:0] dm_wdata, dm_rdata;
  logic [12:0] mem_addr;
  logic        mem_rd, mem_wr, busy;
  logic [15:0] mem_wdata, mem_rdata;

  logic        if_req_1, if_gnt_1, if_rvalid_1;
  logic [12:0] if_addr_1;
  logic [15:0] if_rdata_1;
  logic        dm_req_1, dm_we_1, dm_gnt_1, dm_rvalid_1;
  logic [12:0] dm_addr_1;
  logic [15:0] dm_wdata_1, dm_rdata_1;
  logic [12:0] mem_addr_1;
  logic        mem_rd_1, mem_wr_1, busy_1;
  logic [15:0] mem_wdata_1, mem_rdata_1;

  logic [67:0] all_out, all_out_1;
  assign all_out   = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                      mem_addr, mem_rd, mem_wr, mem_wdata, busy};
  assign all_out_1 = {if_gnt_1, if_rvalid_1, if_rdata_1, dm_gnt_1, dm_rvalid_1, dm_rdata_1,
                      mem_addr_1, mem_rd_1, mem_wr_1, mem_wdata_1, busy_1};

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1),
    .if_rdata(if_rdata_1),
    .dm_req(dm_req_1), .dm_we(dm_we_1), .dm_addr(dm_addr_1), .dm_wdata(dm_wdata_1),
    .dm_gnt(dm_gnt_1), .dm_rvalid(dm_rvalid_1), .dm_rdata(dm_rdata_1),
    .mem_addr(mem_addr_1), .mem_rd(mem_rd_1), .mem_wr(mem_wr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .busy(busy_1)
  );

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_req = 1'($urandom); if_addr = 13'($urandom);
      dm_req = 1'($urandom); dm_we = 1'($urandom);
      dm_addr = 13'($urandom); dm_wdata = 16'($urandom); mem_rdata = 16'($urandom);
      tick();
      checks++;
      if (all_out !== 68'd0) begin
        failures++; $display("FAIL reset_outputs cycle=%0d got=%h exp=0", i, all_out);
      end
    end
    checks++;
    if (all_out_1 !== 68'd0) begin
      failures++; $display("FAIL reset_outputs_lat1 got=%h exp=0", all_out_1);
    end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, if_gnt, dm_gnt, mem_rd, mem_wr} !== 5'b0) begin
        failures++;
        $display("FAIL reset_release_idle cycle=%0d got busy=%b gnt=%b%b rd/wr=%b%b exp=0",
                 i, busy, if_gnt, dm_gnt, mem_rd, mem_wr);
      end
    end
  endtask

  // Issues one fetch from IDLE (cycle 0) and checks the full MEM_LAT=2 timeline.
  task automatic run_fetch(input logic [12:0] a, input logic [15:0] d);
    if_req = 1'b1; if_addr = a; mem_rdata = ~d;
    tick();
    checks++;
    if ({if_gnt, mem_rd, mem_wr, busy, dm_gnt} !== 5'b11010 || mem_addr !== a) begin
      failures++;
      $display("FAIL fetch_issue got gnt/rd/wr/busy/dgnt=%b addr=%h exp=11010 addr=%h",
               {if_gnt, mem_rd, mem_wr, busy, dm_gnt}, mem_addr, a);
    end
    if_req = 1'b0; if_addr = ~a;
    tick();
    checks++;
    if ({if_gnt, mem_rd, if_rvalid, busy} !== 4'b0001) begin
      failures++;
      $display("FAIL fetch_wait got gnt/rd/rvalid/busy=%b exp=0001", {if_gnt, mem_rd, if_rvalid, busy});
    end
    tick();
    mem_rdata = d;
    checks++;
    if (if_rvalid !== 1'b0) begin
      failures++; $display("FAIL fetch_early_rvalid got=%b exp=0", if_rvalid);
    end
    tick();
    mem_rdata = ~d;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== d || dm_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_rvalid got rvalid=%b rdata=%h drvalid=%b exp 1 %h 0",
               if_rvalid, if_rdata, dm_rvalid, d);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || if_rvalid !== 1'b0 || if_rdata !== d || mem_addr !== a) begin
      failures++;
      $display("FAIL fetch_done got busy=%b rvalid=%b rdata=%h addr=%h exp 0 0 %h %h",
               busy, if_rvalid, if_rdata, mem_addr, d, a);
    end
    checks++;
    if ({dm_gnt, dm_rvalid, dm_rdata} !== 18'd0) begin
      failures++; $display("FAIL fetch_dm_quiet got=%h exp=0", {dm_gnt, dm_rvalid, dm_rdata});
    end
  endtask

  task automatic test_single_fetch();
    run_fetch(13'h0040, 16'hA5C3);
  endtask

  task automatic run_data(input logic we, input logic [12:0] a, input logic [15:0] wd,
                          input logic [15:0] md, input logic [15:0] exp_rd);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; mem_rdata = ~md;
    tick();
    checks++;
    if ({dm_gnt, if_gnt, mem_rd, mem_wr} !== {2'b10, !we, we} || mem_addr !== a) begin
      failures++;
      $display("FAIL data_issue we=%b got dgnt/igNt/rd/wr=%b addr=%h exp=%b addr=%h",
               we, {dm_gnt, if_gnt, mem_rd, mem_wr}, mem_addr, {2'b10, !we, we}, a);
    end
    if (we) begin
      checks++;
      if (mem_wdata !== wd) begin
        failures++; $display("FAIL data_wdata got=%h exp=%h", mem_wdata, wd);
      end
    end
    dm_req = 1'b0; dm_addr = ~a; dm_wdata = ~wd;
    tick();
    tick();
    mem_rdata = md;
    checks++;
    if (dm_rvalid !== 1'b0) begin
      failures++; $display("FAIL data_early_rvalid got=%b exp=0", dm_rvalid);
    end
    tick();
    mem_rdata = ~md;
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== exp_rd || if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL data_rvalid we=%b got rvalid=%b rdata=%h irvalid=%b exp 1 %h 0",
               we, dm_rvalid, dm_rdata, if_rvalid, exp_rd);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || dm_rvalid !== 1'b0 || dm_rdata !== exp_rd ||
        (we && mem_wdata !== wd)) begin
      failures++;
      $display("FAIL data_done got busy=%b rvalid=%b rdata=%h wdata=%h exp 0 0 %h",
               busy, dm_rvalid, dm_rdata, mem_wdata, exp_rd);
    end
  endtask

  task automatic test_data_read_write();
    run_data(1'b0, 13'h0005, 16'h0000, 16'h1234, 16'h1234);
    run_data(1'b1, 13'h1FFF, 16'hBEEF, 16'hDEAD, 16'h1234);
  endtask

  task automatic test_back_to_back();
    int ng = 0;
    int last = 0;
    logic exp_dm;
    if_req = 1'b1; if_addr = 13'h0200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 13'h0300; mem_rdata = 16'h7777;
    for (int c = 1; c <= 60 && ng < 10; c++) begin
      tick();
      if (if_gnt || dm_gnt) begin
        exp_dm = ((ng % 5) != 4);
        checks++;
        if (dm_gnt !== exp_dm || if_gnt !== !exp_dm) begin
          failures++;
          $display("FAIL b2b_order grant=%0d got d/f=%b%b exp=%b%b", ng, dm_gnt, if_gnt, exp_dm, !exp_dm);
        end
        checks++;
        if (c - last !== 4 && !(ng == 0 && c == 1)) begin
          failures++; $display("FAIL b2b_spacing grant=%0d got cycle=%0d prev=%0d exp gap 4", ng, c, last);
        end
        last = c;
        ng++;
      end
    end
    checks++;
    if (ng !== 10) begin
      failures++; $display("FAIL b2b_timeout got grants=%0d exp=10", ng);
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_drain got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    if_req = 1'b1; if_addr = 13'h0100; mem_rdata = 16'hFFFF;
    tick();
    if_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== 68'd0) begin
      failures++; $display("FAIL midwait_reset_outputs got=%h exp=0", all_out);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({if_rvalid, dm_rvalid, busy, if_rdata} !== 19'd0) begin
        failures++;
        $display("FAIL midwait_no_rvalid cycle=%0d got rv=%b%b busy=%b rdata=%h exp=0",
                 i, if_rvalid, dm_rvalid, busy, if_rdata);
      end
    end
    run_fetch(13'h0ABC, 16'h5A5A);
  endtask

  task automatic test_lat1();
    dm_req_1 = 1'b1; dm_we_1 = 1'b0; dm_addr_1 = 13'h0077; mem_rdata_1 = 16'h0000;
    tick();
    checks++;
    if ({dm_gnt_1, mem_rd_1, mem_wr_1} !== 3'b110 || mem_addr_1 !== 13'h0077) begin
      failures++;
      $display("FAIL lat1_issue got gnt/rd/wr=%b addr=%h exp=110 addr=0077",
               {dm_gnt_1, mem_rd_1, mem_wr_1}, mem_addr_1);
    end
    dm_req_1 = 1'b0;
    tick();
    mem_rdata_1 = 16'hC0DE;
    checks++;
    if (dm_rvalid_1 !== 1'b0 || busy_1 !== 1'b1) begin
      failures++; $display("FAIL lat1_wait got rvalid=%b busy=%b exp 0 1", dm_rvalid_1, busy_1);
    end
    tick();
    mem_rdata_1 = 16'h0000;
    checks++;
    if (dm_rvalid_1 !== 1'b1 || dm_rdata_1 !== 16'hC0DE) begin
      failures++; $display("FAIL lat1_rvalid got rvalid=%b rdata=%h exp 1 c0de", dm_rvalid_1, dm_rdata_1);
    end
    tick();
    checks++;
    if (busy_1 !== 1'b0 || dm_rvalid_1 !== 1'b0) begin
      failures++; $display("FAIL lat1_done got busy=%b rvalid=%b exp 0 0", busy_1, dm_rvalid_1);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    if_req_1 = 1'b0; if_addr_1 = '0; dm_req_1 = 1'b0; dm_we_1 = 1'b0;
    dm_addr_1 = '0; dm_wdata_1 = '0; mem_rdata_1 = '0;
    test_reset();
    test_single_fetch();
    test_data_read_write();
    test_back_to_back();
    test_reset_mid_wait();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single shared program/data memory between the instruction-fetch requester and the data-memory requester of the multi-cycle CPU.
- Issues one access at a time and waits the fixed memory latency. Returns read data or write acknowledge to the owning requester.
- Data accesses have priority over fetch, with a starvation bound guaranteeing fetch progress.
- Sits between the controller/datapath request signals and the memory array.

Parameters:
- ADDR_W, 13, address width (matches PC width).
- DATA_W, 16, memory word width.
- MEM_LAT, 2, cycles from the mem_rd cycle to the cycle mem_rdata is valid; legal range >=1.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word, registered.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_gnt  out  1  one-cycle pulse: data request accepted.
- dm_rvalid  out  1  one-cycle pulse: read data valid, or write complete.
- dm_rdata  out  DATA_W  read word, registered; unchanged on writes.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_rd  out  1  one-cycle read strobe.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_rd.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, starve_cnt=0. All outputs 0, including the rdata/addr/wdata registers. Reset mid-transaction drops the access; no rvalid is produced afterwards.
- States and transitions:
  - IDLE: arbitrate. A winner moves to ISSUE next cycle; no request stays in IDLE.
  - ISSUE (1 cycle): mem_addr, mem_wdata and owner are latched at entry. mem_rd or mem_wr=1 and the winner's gnt=1 this cycle. Then WAIT.
  - WAIT (MEM_LAT cycles, down-counter): mem_rdata is captured into the owner's rdata register on the last WAIT cycle (the cycle = ISSUE+MEM_LAT). Then RESP.
  - RESP (1 cycle): owner's rvalid=1. Arbitrate again: a winner goes to ISSUE, otherwise IDLE. This allows back-to-back access every MEM_LAT+2 cycles.
- Arbitration happens in IDLE and RESP only:
  - Grant fetch if if_req=1 and (dm_req=0 or starve_cnt==STARVE_MAX). Otherwise grant data if dm_req=1.
  - starve_cnt: +1 when data is granted while if_req=1; cleared when fetch is granted, or at any arbitration where if_req=0. Saturates at STARVE_MAX.
- Requests are sampled only at arbitration. Req/addr changes during a transaction are ignored. A requester keeping req high after its gnt is treated as a new request.
- Write: mem_wdata=dm_wdata. dm_rvalid pulses in RESP as the completion ack. dm_rdata holds its previous value.
- mem_addr/mem_wdata hold their last value outside ISSUE. Only the owner's gnt/rvalid ever pulse.
- Latency with MEM_LAT=2, req at cycle 0 in IDLE: gnt/mem_rd cycle 1, capture cycle 3, rvalid cycle 4, next ISSUE cycle 5.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, busy=0. Deassert with no reqs -> stays IDLE.
- Single fetch: if_req, if_addr=13'h0040 at cycle 0, memory returns 16'hA5C3 at cycle 3 -> if_gnt and mem_rd cycle 1 with mem_addr=0x0040; if_rvalid cycle 4 with if_rdata=16'hA5C3; dm_* outputs stay 0.
- Data write: dm_req, dm_we=1, dm_addr=0x1FFF, dm_wdata=0xBEEF -> mem_wr cycle 1 with mem_addr=0x1FFF, mem_wdata=0xBEEF; dm_rvalid cycle 4; dm_rdata unchanged.
- Simultaneous requests, both held continuously (STARVE_MAX=4) -> grant order D,D,D,D,F,D,D,D,D,F. ISSUE cycles spaced 4 cycles apart.
- Reset mid-WAIT: assert reset in cycle 2 of a read -> outputs 0 immediately; no rvalid after release; the next request completes normally.
- MEM_LAT=1 build: read -> gnt cycle 1, capture cycle 2, rvalid cycle 3.
